// File: rtl/trap_pkg.sv
// trap_pkg: shared state type, cause/stage codes and default handler entry for trap_ctrl
package trap_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, DRAIN, REDIRECT, HANDLER, FATAL} trap_state_t;
  localparam logic [4:0] CAUSE_MISALIGNED_FETCH = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL_INSN = 5'd2;
  localparam logic [4:0] CAUSE_MISALIGNED_LOAD = 5'd4;
  localparam logic [4:0] CAUSE_MISALIGNED_STORE = 5'd6;
  localparam int STG_MEM = 0;
  localparam int STG_EX = 1;
  localparam int STG_ID = 2;
  localparam int STG_IF = 3;
  localparam logic [31:0] DEFAULT_HANDLER_BASE = 32'h0000_2000;
endpackage

// File: rtl/trap_prio_sel.sv
// trap_prio_sel: fixed-priority select of the lowest request plus thermometer mask of it and all higher indices
module trap_prio_sel #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          any_valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  mask
);
  always_comb begin
    idx = '0;
    mask = req;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
    for (int i = 1; i < N; i++) mask[i] = mask[i] | mask[i-1];
    any_valid = |req;
  end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: precise-exception controller that flushes from the oldest faulting stage, drains, and redirects to the handler
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 5,
  parameter logic [XLEN-1:0] HANDLER_BASE = DEFAULT_HANDLER_BASE,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         exc_valid,
  input  logic [NUM_SRC*CAUSE_W-1:0] exc_cause,
  input  logic [NUM_SRC*XLEN-1:0]    exc_pc,
  input  logic [NUM_SRC*XLEN-1:0]    exc_tval,
  input  logic                       sb_empty,
  input  logic                       iret_valid,
  output logic [NUM_SRC-1:0]         flush_o,
  output logic                       stall_o,
  output logic                       redirect_valid,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [XLEN-1:0]            rm_epc,
  output logic [XLEN-1:0]            rm_tval,
  output logic [CAUSE_W-1:0]         rm_cause,
  output logic                       in_handler,
  output logic                       halt,
  output logic [CNT_W-1:0]           exc_count
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  trap_state_t state, next;
  logic any_valid, accept, iret_ok;
  logic [IW-1:0] win;
  logic [NUM_SRC-1:0] win_mask, mask_q;
  logic [XLEN-1:0] rpc_q;
  trap_prio_sel #(.N(NUM_SRC), .IW(IW)) u_sel (
    .req(exc_valid),
    .any_valid(any_valid),
    .idx(win),
    .mask(win_mask)
  );
  assign accept = any_valid && (state == IDLE || state == HANDLER);
  assign iret_ok = state == HANDLER && iret_valid && !any_valid;
  always_comb begin
    next = state == IDLE     ? (any_valid ? FLUSH : IDLE) :
           state == FLUSH    ? DRAIN :
           state == DRAIN    ? (sb_empty ? REDIRECT : DRAIN) :
           state == REDIRECT ? HANDLER :
           state == HANDLER  ? (any_valid ? FATAL : iret_valid ? IDLE : HANDLER) :
           state;
    redirect_valid = state == REDIRECT || iret_ok;
    redirect_pc = state == REDIRECT ? HANDLER_BASE : iret_ok ? rm_epc : rpc_q;
    flush_o = state == FLUSH ? mask_q : (state == REDIRECT || state == FATAL || iret_ok) ? '1 : '0;
    stall_o = state == FLUSH || state == DRAIN || state == FATAL;
    in_handler = state == HANDLER;
    halt = state == FATAL;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mask_q <= '0;
      rpc_q <= '0;
      rm_epc <= '0;
      rm_tval <= '0;
      rm_cause <= '0;
      exc_count <= '0;
    end else begin
      state <= next;
      rpc_q <= redirect_pc;
      if (accept) begin
        mask_q <= win_mask;
        rm_epc <= exc_pc[win*XLEN +: XLEN];
        rm_tval <= exc_tval[win*XLEN +: XLEN];
        rm_cause <= exc_cause[win*CAUSE_W +: CAUSE_W];
        exc_count <= &exc_count ? exc_count : exc_count + 1'b1;
      end
    end
  end
endmodule
